// File: rtl/dmem_responder.sv
// Data-side memory responder: byte-lane RAM plus an MMIO window (TOHOST, console FIFO, status, cycle counter).
// Define DMEM_CONSOLE_EN to build the console FIFO with its CONSOLE and STATUS registers.
module dmem_responder #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] MMIO_BASE = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic        dmem_we,
    input  logic [2:0]  dmem_type,
    output logic [31:0] dmem_data,
    output logic        halt,
    output logic [31:0] tohost_value,
    output logic        misalign_err,
    output logic        console_valid,
    output logic [7:0]  console_data,
    input  logic        console_ready
);

    localparam int          AW           = $clog2(DEPTH);
    localparam logic [31:0] RAM_BYTES    = 32'(4 * DEPTH);
    localparam logic [2:0]  REG_TOHOST   = 3'd0;
    localparam logic [2:0]  REG_CONSOLE  = 3'd1;
    localparam logic [2:0]  REG_STATUS   = 3'd2;
    localparam logic [2:0]  REG_CYCLE_LO = 3'd4;
    localparam logic [2:0]  REG_CYCLE_HI = 3'd5;

    logic [31:0]   mem [DEPTH];
    logic [63:0]   cycle_count;
    logic [31:0]   status_word;
    logic [31:0]   rdata_word;
    logic [31:0]   wdata_rep;
    logic [3:0]    byte_en;
    logic [AW-1:0] word_idx;
    logic [2:0]    reg_sel;
    logic          is_byte, is_half, is_word;
    logic          misaligned, in_ram, in_mmio;
    logic          ram_we, mmio_we, tohost_we;
    logic          unused_type_bit;

    // Bit 2 of the type only selects sign/zero extension, which the core does itself.
    assign unused_type_bit = dmem_type[2];

    assign is_byte    = (dmem_type[1:0] == 2'b00);
    assign is_half    = (dmem_type[1:0] == 2'b01);
    assign is_word    = !is_byte && !is_half;
    assign misaligned = (is_half && dmem_addr[0]) || (is_word && (dmem_addr[1:0] != 2'b00));
    assign in_ram     = (dmem_addr < RAM_BYTES);
    assign in_mmio    = (dmem_addr[31:5] == MMIO_BASE[31:5]);
    assign word_idx   = dmem_addr[AW+1:2];
    assign reg_sel    = dmem_addr[4:2];

    assign ram_we    = dmem_we && rst_n && in_ram && !misaligned;
    assign mmio_we   = dmem_we && in_mmio && !misaligned;
    assign tohost_we = mmio_we && (reg_sel == REG_TOHOST) && is_word;

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        byte_en   = 4'b1111;
        wdata_rep = dmem_wdata;
        if (is_byte) begin
            byte_en   = 4'b0001 << dmem_addr[1:0];
            wdata_rep = {4{dmem_wdata[7:0]}};
        end else if (is_half) begin
            byte_en   = dmem_addr[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{dmem_wdata[15:0]}};
        end
    end

    // NOTE: RAM has no reset branch; contents survive reset and it maps onto plain memory.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt         <= 1'b0;
            tohost_value <= 32'h0;
            misalign_err <= 1'b0;
            cycle_count  <= 64'h0;
        end else begin
            misalign_err <= misaligned;
            cycle_count  <= cycle_count + 64'd1;
            if (tohost_we) begin
                halt         <= 1'b1;
                tohost_value <= dmem_wdata;
            end
        end
    end

`ifdef DMEM_CONSOLE_EN
    logic [7:0] fifo_mem [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] fifo_count;
    logic       overflow, fifo_full, console_push, pop, push_ok;

    assign fifo_full     = (fifo_count == 3'd4);
    assign console_push  = mmio_we && (reg_sel == REG_CONSOLE) && is_byte;
    assign pop           = console_valid && console_ready;
    assign push_ok       = console_push && (!fifo_full || pop);
    assign console_valid = (fifo_count != 3'd0);
    assign console_data  = console_valid ? fifo_mem[rd_ptr] : 8'h00;
    assign status_word   = {27'h0, overflow, fifo_full, fifo_count};

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= dmem_wdata[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            fifo_count <= 3'd0;
            overflow   <= 1'b0;
        end else begin
            if (pop)     rd_ptr <= rd_ptr + 2'd1;
            if (push_ok) wr_ptr <= wr_ptr + 2'd1;
            fifo_count <= fifo_count + {2'b00, push_ok} - {2'b00, pop};
            if (console_push && fifo_full && !pop) overflow <= 1'b1;
        end
    end
`else
    logic unused_console_ready;

    assign unused_console_ready = console_ready;
    assign console_valid        = 1'b0;
    assign console_data         = 8'h00;
    assign status_word          = 32'h0;
`endif

    always_comb begin
        rdata_word = 32'h0;
        if (in_ram) begin
            rdata_word = mem[word_idx];
        end else if (in_mmio) begin
            case (reg_sel)
                REG_TOHOST:   rdata_word = tohost_value;
                REG_CONSOLE:  rdata_word = 32'h0;
                REG_STATUS:   rdata_word = status_word;
                REG_CYCLE_LO: rdata_word = cycle_count[31:0];
                REG_CYCLE_HI: rdata_word = cycle_count[63:32];
                default:      rdata_word = 32'h0;
            endcase
        end
    end

    assign dmem_data = rdata_word >> {dmem_addr[1:0], 3'b000};

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder; console steps follow DMEM_CONSOLE_EN.
module tb_dmem_responder;

    localparam logic [31:0] MB = 32'h1000_0000;
    localparam logic [2:0]  T_B = 3'b000, T_H = 3'b001, T_W = 3'b010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] dmem_addr, dmem_wdata, dmem_data, tohost_value;
    logic        dmem_we, halt, misalign_err, console_valid, console_ready;
    logic [2:0]  dmem_type;
    logic [7:0]  console_data;
    logic [31:0] lo0;
    int          checks = 0;
    int          failures = 0;

    dmem_responder dut (
        .clk(clk), .rst_n(rst_n), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_we(dmem_we), .dmem_type(dmem_type), .dmem_data(dmem_data), .halt(halt),
        .tohost_value(tohost_value), .misalign_err(misalign_err),
        .console_valid(console_valid), .console_data(console_data), .console_ready(console_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
        dmem_addr = a; dmem_wdata = d; dmem_type = t; dmem_we = 1'b1;
        tick();
        dmem_we = 1'b0; dmem_addr = 32'h0; dmem_type = T_W;
    endtask

    task automatic load(input logic [31:0] a, input logic [2:0] t);
        dmem_addr = a; dmem_type = t;
        #1;
    endtask

`ifdef DMEM_CONSOLE_EN
    task automatic drain(input logic [7:0] e0, e1, e2, e3);
        logic [7:0] exp_q [4];
        exp_q[0] = e0; exp_q[1] = e1; exp_q[2] = e2; exp_q[3] = e3;
        console_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_valid_%0d", i), console_valid, 1'b1);
            check($sformatf("drain_data_%0d", i), console_data, exp_q[i]);
            tick();
        end
        check("drain_empty", console_valid, 1'b0);
        console_ready = 1'b0;
    endtask
`endif

    initial begin
        rst_n = 1'b0; dmem_addr = 32'h0; dmem_wdata = 32'h0; dmem_we = 1'b0;
        dmem_type = T_W; console_ready = 1'b0;
        #2;
        check("rst_halt", halt, 1'b0);
        check("rst_tohost", tohost_value, 32'h0);
        check("rst_misalign", misalign_err, 1'b0);
        check("rst_cvalid", console_valid, 1'b0);
        check("rst_cdata", console_data, 8'h00);
        load(MB + 32'h10, T_W);
        check("rst_cycle_lo", dmem_data, 32'h0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Byte/half/word stores and shifted loads
        store(32'h10, 32'hDEAD_BEEF, T_W);
        load(32'h13, T_B);
        check("byte_load_13", dmem_data, 32'h0000_00DE);
        store(32'h12, 32'h0000_1234, T_H);
        load(32'h10, T_W);
        check("half_merge", dmem_data, 32'h1234_BEEF);
        store(32'h11, 32'h0000_00A5, T_B);
        load(32'h10, T_W);
        check("byte_merge", dmem_data, 32'h1234_A5EF);
        load(32'h12, T_H);
        check("half_load_12", dmem_data, 32'h0000_1234);

        // RAM edge and out-of-range addresses
        store(32'h0, 32'h0102_0304, T_W);
        store(32'hFFC, 32'hCAFE_F00D, T_W);
        store(32'h1000, 32'hFFFF_FFFF, T_W);
        load(32'hFFC, T_W);
        check("ram_top_word", dmem_data, 32'hCAFE_F00D);
        load(32'h0, T_W);
        check("no_alias_word0", dmem_data, 32'h0102_0304);
        load(32'h1000, T_W);
        check("oob_read_zero", dmem_data, 32'h0);
        check("oob_no_misalign", misalign_err, 1'b0);

        // Misaligned store suppressed, pulse lasts one cycle
        store(32'h20, 32'h1122_3344, T_W);
        store(32'h21, 32'hFFFF_FFFF, T_W);
        check("mis_store_pulse", misalign_err, 1'b1);
        tick();
        check("mis_store_clear", misalign_err, 1'b0);
        load(32'h20, T_W);
        check("mis_store_suppressed", dmem_data, 32'h1122_3344);
        load(32'h23, T_H);
        check("mis_load_data", dmem_data, 32'h0000_0011);
        tick();
        dmem_addr = 32'h0; dmem_type = T_W;
        check("mis_load_pulse", misalign_err, 1'b1);
        tick();
        check("mis_load_clear", misalign_err, 1'b0);

        // TOHOST
        store(MB, 32'h1, T_W);
        check("halt_set", halt, 1'b1);
        check("tohost_1", tohost_value, 32'h1);
        store(MB, 32'h5, T_W);
        check("halt_sticky", halt, 1'b1);
        check("tohost_5", tohost_value, 32'h5);
        load(MB, T_W);
        check("tohost_read", dmem_data, 32'h5);

        // Cycle counter
        load(MB + 32'h10, T_W);
        lo0 = dmem_data;
        tick();
        check("cycle_delta", dmem_data - lo0, 32'd1);
        load(MB + 32'h14, T_W);
        check("cycle_hi", dmem_data, 32'h0);

`ifdef DMEM_CONSOLE_EN
        for (int i = 0; i < 5; i++) store(MB + 32'h4, 32'h41 + i, T_B);
        load(MB + 32'h8, T_W);
        check("status_overflow", dmem_data, 32'h1C);
        check("head_A", console_data, 8'h41);
        tick();
        check("head_hold", console_data, 8'h41);
        drain(8'h41, 8'h42, 8'h43, 8'h44);
        load(MB + 32'h8, T_W);
        check("status_after_drain", dmem_data, 32'h10);
        load(MB + 32'h4, T_W);
        check("console_read_zero", dmem_data, 32'h0);

        for (int i = 0; i < 4; i++) store(MB + 32'h4, 32'h31 + i, T_B);
        dmem_addr = MB + 32'h4; dmem_wdata = 32'h58; dmem_type = T_B; dmem_we = 1'b1;
        console_ready = 1'b1;
        tick();
        dmem_we = 1'b0; console_ready = 1'b0;
        load(MB + 32'h8, T_W);
        check("push_pop_full", dmem_data, 32'h1C);
        drain(8'h32, 8'h33, 8'h34, 8'h58);

        store(MB + 32'h4, 32'h51, T_B);
        check("pre_reset_valid", console_valid, 1'b1);
`else
        console_ready = 1'b1;
        store(MB + 32'h4, 32'h41, T_B);
        check("nocon_valid", console_valid, 1'b0);
        check("nocon_data", console_data, 8'h00);
        load(MB + 32'h8, T_W);
        check("nocon_status", dmem_data, 32'h0);
        console_ready = 1'b0;
`endif

        // Asynchronous reset mid-run; RAM survives, store during reset is lost
        load(MB + 32'h10, T_W);
        rst_n = 1'b0;
        #1;
        check("midrst_cycle", dmem_data, 32'h0);
        check("midrst_halt", halt, 1'b0);
        check("midrst_tohost", tohost_value, 32'h0);
        check("midrst_cvalid", console_valid, 1'b0);
        load(MB + 32'h8, T_W);
        check("midrst_status", dmem_data, 32'h0);
        store(32'h10, 32'hBADB_AD00, T_W);
        rst_n = 1'b1;
        load(32'h10, T_W);
        check("ram_survives_reset", dmem_data, 32'h1234_A5EF);
        load(32'hFFC, T_W);
        check("ram_top_survives", dmem_data, 32'hCAFE_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
